multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32; width of the instret counter.
REQ-002 Parameter MEM_TIMEOUT, default 15; maximum wait cycles for any memory ack, range 1..255.
REQ-003 Port clk, input, 1; the single clock, all state changes on its rising edge.
REQ-004 Port rst_n, input, 1; reset, asynchronous, active-low.
REQ-005 Port dec_flags, input, 11; decoder outputs {is_system, is_store, is_load, is_alu_imm, is_auipc, is_lui, is_branch, is_jalr, is_jal, reg_write, is_alu_reg}, bit 10 down to bit 0.
REQ-006 Port branch_taken, input, 1; branch comparator result, valid in EXEC.
REQ-007 Port imem_ack, input, 1; instruction word valid this cycle.
REQ-008 Port dmem_ack, input, 1; data access complete this cycle.
REQ-009 Port imem_req, output, 1; instruction fetch request.
REQ-010 Port ir_we, output, 1; instruction register load strobe.
REQ-011 Port dmem_req, output, 1; data access request.
REQ-012 Port dmem_we, output, 1; data access is a write.
REQ-013 Port pc_we, output, 1; PC update strobe.
REQ-014 Port pc_sel, output, 2; 0 = PC+4, 1 = PC+imm (branch/jal), 2 = rs1+imm (jalr).
REQ-015 Port reg_we, output, 1; register file write strobe.
REQ-016 Port wb_sel, output, 2; 0 = ALU, 1 = load data, 2 = PC+4, 3 = U-immediate.
REQ-017 Port halt, output, 1; core stopped on a SYSTEM instruction.
REQ-018 Port fault, output, 1; core stopped on an illegal opcode or memory timeout.
REQ-019 Port state, output, 3; current FSM state encoding.
REQ-020 Port instret, output, DATA_WIDTH; count of retired instructions.

Function
REQ-021 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; code 7 SHALL go to FAULT on the next edge.
REQ-022 All strobe outputs SHALL be combinational from state, dec_flags, branch_taken and the acks, and SHALL be 0 in any state or case not listed below.
REQ-023 FETCH: imem_req=1; on imem_ack, ir_we=1 and next state DECODE; otherwise remain in FETCH.
REQ-024 DECODE: is_system -> HALT; no bit among dec_flags[10:2] or dec_flags[0] set -> FAULT; otherwise -> EXEC.
REQ-025 EXEC: is_load or is_store -> MEM; else reg_write -> WB; else (branch) pc_we=1, pc_sel=branch_taken?1:0, retire, -> FETCH.
REQ-026 MEM: dmem_req=1, dmem_we=is_store, held stable until dmem_ack.
REQ-027 MEM on dmem_ack: store -> pc_we=1, pc_sel=0, retire, -> FETCH; load -> WB.
REQ-028 WB: reg_we=1; wb_sel=1 for load, 2 for jal/jalr, 3 for lui, 0 otherwise (auipc uses the ALU path).
REQ-029 WB: pc_we=1; pc_sel=1 for jal, 2 for jalr, 0 otherwise; retire; -> FETCH.
REQ-030 Retire SHALL mean instret increments by 1 on that edge, wrapping from all-ones to 0.
REQ-031 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle in that state without an ack.
REQ-032 When the wait counter equals MEM_TIMEOUT and no ack is present, next state SHALL be FAULT; an ack in that same cycle SHALL win.
REQ-033 HALT and FAULT SHALL be sticky until reset, with halt=1 and fault=1 respectively and all strobes 0.
REQ-034 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-035 dec_flags SHALL be treated as stable from DECODE through WB, since they derive from the IR.

Reset
REQ-036 rst_n low SHALL immediately force state=FETCH, wait counter=0 and instret=0, with all strobes, halt and fault at 0, from any state including mid-MEM.
REQ-037 After rst_n deasserts, imem_req SHALL assert in FETCH on the first cycle.

Verification
REQ-038 R-type (is_alu_reg, reg_write), imem_ack 1 cycle after req -> FETCH, DECODE, EXEC, WB: reg_we=1, wb_sel=0, pc_sel=0; instret=1 after 5 cycles.
REQ-039 Load, dmem_ack 3 cycles into MEM -> dmem_req high 3 cycles, dmem_we=0, then WB with wb_sel=1; instret=1.
REQ-040 Branch with branch_taken=1, then branch_taken=0 -> pc_we=1 in EXEC with pc_sel=1, then pc_sel=0; reg_we never asserted; instret=2.
REQ-041 MEM_TIMEOUT=15, no dmem_ack -> FAULT after 16 MEM cycles, fault=1 held; ack in the 16th cycle instead -> normal completion.
REQ-042 is_system -> halt=1 and state=5 remain indefinitely; all-zero dec_flags -> fault=1.
REQ-043 rst_n low mid-MEM during a store -> dmem_req drops in the same cycle, state=0, instret=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/writeback control FSM for a multicycle core,
// with retired-instruction counting and a memory-ack timeout that drops into a sticky fault.
module multicycle_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           dec_flags,
  input  logic                  branch_taken,
  input  logic                  imem_ack,
  input  logic                  dmem_ack,
  output logic                  imem_req,
  output logic                  ir_we,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic                  halt,
  output logic                  fault,
  output logic [2:0]            state,
  output logic [DATA_WIDTH-1:0] instret
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } state_t;
  state_t     cur, nxt;
  logic [7:0] wait_cnt;
  logic       retire, timeout, legal;
  logic       is_system, is_store, is_load, is_lui, is_jalr, is_jal, reg_write;
  assign is_system = dec_flags[10];
  assign is_store  = dec_flags[9];
  assign is_load   = dec_flags[8];
  assign is_lui    = dec_flags[5];
  assign is_jalr   = dec_flags[3];
  assign is_jal    = dec_flags[2];
  assign reg_write = dec_flags[1];
  assign legal     = |dec_flags[10:2] || dec_flags[0];
  assign timeout   = wait_cnt == 8'(MEM_TIMEOUT);
  assign state     = cur;
  assign halt      = cur == HALT;
  assign fault     = cur == FAULT;
  // Reset forces FETCH asynchronously, so only the FETCH strobes need gating by rst_n.
  always_comb begin
    nxt      = cur;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    reg_we   = 1'b0;
    wb_sel   = 2'd0;
    retire   = 1'b0;
    case (cur)
      FETCH: begin
        imem_req = rst_n;
        ir_we    = rst_n & imem_ack;
        nxt      = imem_ack ? DECODE : timeout ? FAULT : FETCH;
      end
      DECODE: nxt = is_system ? HALT : legal ? EXEC : FAULT;
      EXEC: begin
        nxt    = (is_load || is_store) ? MEM : reg_write ? WB : FETCH;
        pc_we  = !(is_load || is_store || reg_write);
        pc_sel = (pc_we && branch_taken) ? 2'd1 : 2'd0;
        retire = pc_we;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        nxt      = dmem_ack ? (is_store ? FETCH : WB) : timeout ? FAULT : MEM;
        pc_we    = dmem_ack && is_store;
        retire   = pc_we;
      end
      WB: begin
        reg_we = 1'b1;
        wb_sel = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
        pc_we  = 1'b1;
        pc_sel = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        retire = 1'b1;
        nxt    = FETCH;
      end
      HALT:    nxt = HALT;
      FAULT:   nxt = FAULT;
      default: nxt = FAULT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= (nxt != cur) ? '0 : (cur == FETCH || cur == MEM) ? wait_cnt + 8'd1 : wait_cnt;
      if (retire) instret <= instret + DATA_WIDTH'(1);
    end
  end
endmodule
